// File: rtl/intr_cntrl_mx.sv
// Machine-mode interrupt controller: synchronised external lines, software msip and a
// 64-bit mtime/mtimecmp timer, fixed-priority arbitration and a req/service handshake.
module intr_cntrl_mx #(
    parameter int XLEN        = 32,
    parameter int N_EXT       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_EXT-1:0] ext_irq,
    input  logic [N_EXT-1:0] ext_mask,
    input  logic             sw_set,
    input  logic             sw_clr,
    input  logic             cmp_we,
    input  logic [63:0]      cmp_wdata,
    input  logic             timer_en,
    input  logic             mstatus_mie,
    input  logic             mie_msie,
    input  logic             mie_mtie,
    input  logic             mie_meie,
    input  logic             intr_ack,
    input  logic             mret,
    output logic             intr_req,
    output logic [XLEN-1:0]  mcause,
    output logic [3:0]       ext_id,
    output logic [XLEN-1:0]  mip,
    output logic [63:0]      mtime,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam logic [3:0] CODE_MSI = 4'd3;
    localparam logic [3:0] CODE_MTI = 4'd7;
    localparam logic [3:0] CODE_MEI = 4'd11;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_EXT-1:0]  r_sync_p [SYNC_STAGES];
    logic              r_msip;
    logic [63:0]       r_mtime;
    logic [63:0]       r_mtimecmp;
    logic              r_intr_req;
    logic [XLEN-1:0]   r_mcause;
    logic [3:0]        r_ext_id;

    logic [N_EXT-1:0]  w_ext_act;
    logic              w_meip;
    logic              w_mtip;
    logic              w_mei_elig;
    logic              w_msi_elig;
    logic              w_mti_elig;
    logic              w_any_elig;
    logic [3:0]        w_code;
    logic [3:0]        w_ext_id_sel;
    logic [XLEN-1:0]   w_cause;
    logic [XLEN-1:0]   w_mip;
    logic              w_req_nxt;
    logic              w_capture;

    // Stage boundary: asynchronous external lines into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync_p[i] <= '0;
            end
        end else begin
            r_sync_p[0] <= ext_irq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync_p[i] <= r_sync_p[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msip <= 1'b0;
        end else if (sw_clr) begin
            r_msip <= 1'b0;
        end else if (sw_set) begin
            r_msip <= 1'b1;
        end
    end

    // Reset compare value of all-ones keeps MTIP low until mtime wraps up to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
        end else begin
            if (timer_en) begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (cmp_we) begin
                r_mtimecmp <= cmp_wdata;
            end
        end
    end

    assign w_ext_act  = r_sync_p[SYNC_STAGES-1] & ext_mask;
    assign w_meip     = |w_ext_act;
    assign w_mtip     = (r_mtime >= r_mtimecmp);
    assign w_mei_elig = w_meip & mie_meie & mstatus_mie;
    assign w_msi_elig = r_msip & mie_msie & mstatus_mie;
    assign w_mti_elig = w_mtip & mie_mtie & mstatus_mie;
    assign w_any_elig = w_mei_elig | w_msi_elig | w_mti_elig;

    always_comb begin
        w_ext_id_sel = 4'd0;
        for (int i = N_EXT - 1; i >= 0; i--) begin
            if (w_ext_act[i]) begin
                w_ext_id_sel = 4'(i);
            end
        end
    end

    always_comb begin
        w_code = CODE_MTI;
        if (w_mei_elig) begin
            w_code = CODE_MEI;
        end else if (w_msi_elig) begin
            w_code = CODE_MSI;
        end
        w_cause            = '0;
        w_cause[XLEN-1]    = 1'b1;
        w_cause[3:0]       = w_code;
    end

    always_comb begin
        w_mip     = '0;
        w_mip[3]  = r_msip;
        w_mip[7]  = w_mtip;
        w_mip[11] = w_meip;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_intr_req;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_elig) begin
                    w_state_nxt = S_REQ;
                    w_req_nxt   = 1'b1;
                    w_capture   = 1'b1;
                end
            end
            S_REQ: begin
                if (intr_ack) begin
                    w_state_nxt = S_SERVICE;
                    w_req_nxt   = 1'b0;
                end
            end
            S_SERVICE: begin
                if (mret) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    // Stage boundary: request and cause registered toward the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_intr_req <= 1'b0;
            r_mcause   <= '0;
            r_ext_id   <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_intr_req <= w_req_nxt;
            if (w_capture) begin
                r_mcause <= w_cause;
                r_ext_id <= w_mei_elig ? w_ext_id_sel : 4'd0;
            end
        end
    end

    assign intr_req = r_intr_req;
    assign mcause   = r_mcause;
    assign ext_id   = r_ext_id;
    assign mip      = w_mip;
    assign mtime    = r_mtime;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_intr_cntrl_mx.sv
// Bench for intr_cntrl_mx: directed scenarios plus randomized traffic against a
// behavioural model of pending sources and the request/service handshake.
module tb_intr_cntrl_mx;

    localparam int XLEN = 32;
    localparam int NE   = 4;
    localparam int SS   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NE-1:0]   ext_irq, ext_mask;
    logic            sw_set, sw_clr, cmp_we;
    logic [63:0]     cmp_wdata;
    logic            timer_en, mstatus_mie, mie_msie, mie_mtie, mie_meie;
    logic            intr_ack, mret;
    logic            intr_req;
    logic [XLEN-1:0] mcause;
    logic [3:0]      ext_id;
    logic [XLEN-1:0] mip;
    logic [63:0]     mtime;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [NE-1:0]   m_q[$];
    logic            m_msip;
    logic [63:0]     m_mtime, m_cmp;
    logic            m_req, m_busy;
    logic [31:0]     m_cause;
    logic [3:0]      m_extid;

    intr_cntrl_mx #(.XLEN(XLEN), .N_EXT(NE), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .ext_irq(ext_irq), .ext_mask(ext_mask),
        .sw_set(sw_set), .sw_clr(sw_clr), .cmp_we(cmp_we), .cmp_wdata(cmp_wdata),
        .timer_en(timer_en), .mstatus_mie(mstatus_mie), .mie_msie(mie_msie),
        .mie_mtie(mie_mtie), .mie_meie(mie_meie), .intr_ack(intr_ack), .mret(mret),
        .intr_req(intr_req), .mcause(mcause), .ext_id(ext_id), .mip(mip),
        .mtime(mtime), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [NE-1:0] m_synced();
        if (m_q.size() < SS) return '0;
        return m_q[SS-1];
    endfunction

    function automatic logic [3:0] lowest(input logic [NE-1:0] v);
        logic [3:0] r = 4'd0;
        for (int i = NE - 1; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    function automatic logic [31:0] exp_mip();
        logic [31:0] r = '0;
        r[3]  = m_msip;
        r[7]  = (m_mtime >= m_cmp);
        r[11] = |(m_synced() & ext_mask);
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_msip  = 1'b0;
        m_mtime = '0;
        m_cmp   = '1;
        m_req   = 1'b0;
        m_busy  = 1'b0;
        m_cause = '0;
        m_extid = '0;
    endtask

    // Advance one clock edge, update the model from the inputs seen at that edge.
    task automatic tick();
        logic [NE-1:0] act;
        logic e_mei, e_msi, e_mti;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            act   = m_synced() & ext_mask;
            e_mei = (|act) & mie_meie & mstatus_mie;
            e_msi = m_msip & mie_msie & mstatus_mie;
            e_mti = (m_mtime >= m_cmp) & mie_mtie & mstatus_mie;
            if (!m_busy) begin
                if (e_mei | e_msi | e_mti) begin
                    m_req   = 1'b1;
                    m_busy  = 1'b1;
                    m_cause = e_mei ? 32'h8000_000B : (e_msi ? 32'h8000_0003 : 32'h8000_0007);
                    m_extid = e_mei ? lowest(act) : 4'd0;
                end
            end else if (m_req) begin
                if (intr_ack) m_req = 1'b0;
            end else if (mret) begin
                m_busy = 1'b0;
            end
            m_q.push_front(ext_irq);
            if (m_q.size() > SS) void'(m_q.pop_back());
            if (sw_clr) m_msip = 1'b0;
            else if (sw_set) m_msip = 1'b1;
            if (timer_en) m_mtime = m_mtime + 64'd1;
            if (cmp_we) m_cmp = cmp_wdata;
        end
        #1;
    endtask

    task automatic clear_inputs();
        ext_irq = '0; ext_mask = '0; sw_set = 0; sw_clr = 0; cmp_we = 0; cmp_wdata = '0;
        timer_en = 0; mstatus_mie = 0; mie_msie = 0; mie_mtie = 0; mie_meie = 0;
        intr_ack = 0; mret = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        n_checks++;
        if ({intr_req, busy} !== 2'b00) begin
            n_fail++; $display("FAIL reset_req_busy: got %b expected 00", {intr_req, busy});
        end
        n_checks++;
        if (mcause !== '0 || ext_id !== 4'd0) begin
            n_fail++; $display("FAIL reset_cause: got mcause=%h ext_id=%0d expected 0/0", mcause, ext_id);
        end
        n_checks++;
        if (mip !== '0 || mtime !== 64'd0) begin
            n_fail++; $display("FAIL reset_mip_mtime: got mip=%h mtime=%0d expected 0/0", mip, mtime);
        end
        rst_n = 1'b1;
        // async reset in the middle of a pending request
        mstatus_mie = 1; mie_msie = 1; timer_en = 1;
        sw_set = 1; tick(); sw_set = 0;
        tick();
        tick();
        n_checks++;
        if (intr_req !== 1'b1 || busy !== 1'b1 || mcause !== 32'h8000_0003) begin
            n_fail++; $display("FAIL reset_setup_req: got req=%b busy=%b mcause=%h expected 1/1/80000003",
                               intr_req, busy, mcause);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (intr_req !== 1'b0 || busy !== 1'b0 || mcause !== '0 || mtime !== 64'd0) begin
            n_fail++; $display("FAIL reset_async: got req=%b busy=%b mcause=%h mtime=%0d expected all 0",
                               intr_req, busy, mcause, mtime);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_priority();
        do_reset();
        mie_meie = 1; mie_msie = 1; mie_mtie = 1; ext_mask = 4'hF;
        cmp_we = 1; cmp_wdata = 64'd0; tick(); cmp_we = 0;
        sw_set = 1; tick(); sw_set = 0;
        ext_irq = 4'b0100; tick(); tick();
        n_checks++;
        if (mip !== 32'h888 || intr_req !== 1'b0) begin
            n_fail++; $display("FAIL gate_mie0: got mip=%h req=%b expected 888/0", mip, intr_req);
        end
        mstatus_mie = 1; tick();
        n_checks++;
        if (intr_req !== 1'b1 || mcause !== 32'h8000_000B || ext_id !== 4'd2) begin
            n_fail++; $display("FAIL prio_mei: got req=%b mcause=%h ext_id=%0d expected 1/8000000b/2",
                               intr_req, mcause, ext_id);
        end
        ext_irq = '0; intr_ack = 1; tick(); intr_ack = 0;
        n_checks++;
        if (intr_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ack_state: got req=%b busy=%b expected 0/1", intr_req, busy);
        end
        tick(); tick();
        mret = 1; tick(); mret = 0;
        n_checks++;
        if (busy !== 1'b0 || intr_req !== 1'b0) begin
            n_fail++; $display("FAIL mret_state: got busy=%b req=%b expected 0/0", busy, intr_req);
        end
        tick();
        n_checks++;
        if (intr_req !== 1'b1 || mcause !== 32'h8000_0003 || ext_id !== 4'd0) begin
            n_fail++; $display("FAIL prio_msi: got req=%b mcause=%h ext_id=%0d expected 1/80000003/0",
                               intr_req, mcause, ext_id);
        end
        intr_ack = 1; tick(); intr_ack = 0;
        sw_clr = 1; tick(); sw_clr = 0;
        mret = 1; tick(); mret = 0;
        tick();
        n_checks++;
        if (intr_req !== 1'b1 || mcause !== 32'h8000_0007) begin
            n_fail++; $display("FAIL prio_mti: got req=%b mcause=%h expected 1/80000007", intr_req, mcause);
        end
    endtask

    task automatic test_ext_select();
        do_reset();
        mstatus_mie = 1; mie_meie = 1; ext_mask = 4'b1000; ext_irq = 4'b1010;
        tick();
        tick();
        n_checks++;
        if (mip[11] !== 1'b1 || intr_req !== 1'b0) begin
            n_fail++; $display("FAIL ext_sync_lat: got meip=%b req=%b expected 1/0", mip[11], intr_req);
        end
        tick();
        n_checks++;
        if (intr_req !== 1'b1 || ext_id !== 4'd3 || mcause !== 32'h8000_000B) begin
            n_fail++; $display("FAIL ext_select: got req=%b ext_id=%0d mcause=%h expected 1/3/8000000b",
                               intr_req, ext_id, mcause);
        end
    endtask

    task automatic test_timer();
        int unsigned cyc;
        bit seen;
        do_reset();
        mstatus_mie = 1; mie_mtie = 1; timer_en = 1;
        cmp_we = 1; cmp_wdata = 64'd20; tick(); cmp_we = 0;
        tick();
        n_checks++;
        if (mip[7] !== 1'b0) begin
            n_fail++; $display("FAIL timer_early: got mtip=%b at mtime=%0d expected 0", mip[7], mtime);
        end
        seen = 0;
        for (cyc = 0; cyc < 60 && !seen; cyc++) begin
            tick();
            if (m_mtime == 64'd19) begin
                n_checks++;
                if (mip[7] !== 1'b0) begin
                    n_fail++; $display("FAIL timer_19: got mtip=%b expected 0", mip[7]);
                end
            end
            if (m_mtime == 64'd20) begin
                seen = 1;
                n_checks++;
                if (mip[7] !== 1'b1 || intr_req !== 1'b0 || mtime !== 64'd20) begin
                    n_fail++; $display("FAIL timer_20: got mtip=%b req=%b mtime=%0d expected 1/0/20",
                                       mip[7], intr_req, mtime);
                end
                tick();
                n_checks++;
                if (intr_req !== 1'b1 || mcause !== 32'h8000_0007) begin
                    n_fail++; $display("FAIL timer_req: got req=%b mcause=%h expected 1/80000007",
                                       intr_req, mcause);
                end
            end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL timer_timeout: mtime never reached 20 (got %0d)", mtime);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        mstatus_mie = 1; mie_meie = 1; ext_mask = 4'hF; ext_irq = 4'b0001;
        tick(); tick(); tick();
        ext_irq = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (intr_req !== 1'b1 || mcause !== 32'h8000_000B || ext_id !== 4'd0) begin
                n_fail++; $display("FAIL freeze_%0d: got req=%b mcause=%h ext_id=%0d expected 1/8000000b/0",
                                   i, intr_req, mcause, ext_id);
            end
        end
        mret = 1; tick(); mret = 0;
        n_checks++;
        if (intr_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mret_in_req: got req=%b busy=%b expected 1/1", intr_req, busy);
        end
        intr_ack = 1; tick(); intr_ack = 0;
        mret = 1; tick(); mret = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (intr_req !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL no_rereq_%0d: got req=%b busy=%b expected 0/0", i, intr_req, busy);
            end
        end
    endtask

    task automatic test_collisions();
        do_reset();
        mie_meie = 1; mie_msie = 1; mie_mtie = 1; ext_mask = 4'hF; ext_irq = 4'hF;
        cmp_we = 1; cmp_wdata = 64'd0; sw_set = 1; tick(); cmp_we = 0; sw_set = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i >= 1) begin
                n_checks++;
                if (mip !== 32'h888 || intr_req !== 1'b0) begin
                    n_fail++; $display("FAIL gate_%0d: got mip=%h req=%b expected 888/0", i, mip, intr_req);
                end
            end
        end
        sw_set = 1; sw_clr = 1; tick(); sw_set = 0; sw_clr = 0;
        n_checks++;
        if (mip[3] !== 1'b0) begin
            n_fail++; $display("FAIL sw_collide: got msip=%b expected 0", mip[3]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) ext_irq = NE'($urandom);
            if ($urandom_range(0, 15) == 0) ext_mask = NE'($urandom);
            sw_set      = ($urandom_range(0, 9) == 0);
            sw_clr      = ($urandom_range(0, 11) == 0);
            cmp_we      = ($urandom_range(0, 19) == 0);
            cmp_wdata   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                      : m_mtime + 64'($urandom_range(0, 40));
            timer_en    = ($urandom_range(0, 3) != 0);
            mstatus_mie = ($urandom_range(0, 7) != 0);
            mie_msie    = ($urandom_range(0, 3) != 0);
            mie_mtie    = ($urandom_range(0, 3) != 0);
            mie_meie    = ($urandom_range(0, 3) != 0);
            intr_ack    = ($urandom_range(0, 3) == 0);
            mret        = ($urandom_range(0, 3) == 0);
            tick();
            n_checks++;
            if (intr_req !== m_req || busy !== m_busy) begin
                n_fail++; $display("FAIL rnd_hs c=%0d: got req=%b busy=%b expected %b/%b",
                                   c, intr_req, busy, m_req, m_busy);
            end
            n_checks++;
            if (mcause !== m_cause || ext_id !== m_extid) begin
                n_fail++; $display("FAIL rnd_cause c=%0d: got mcause=%h ext_id=%0d expected %h/%0d",
                                   c, mcause, ext_id, m_cause, m_extid);
            end
            n_checks++;
            if (mip !== exp_mip() || mtime !== m_mtime) begin
                n_fail++; $display("FAIL rnd_mip c=%0d: got mip=%h mtime=%0d expected %h/%0d",
                                   c, mip, mtime, exp_mip(), m_mtime);
            end
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_priority();
        test_ext_select();
        test_timer();
        test_freeze();
        test_collisions();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
